// File: rtl/mul_iter.sv
// mul_iter: iterative shift-add multiplier for signed (MULT) and unsigned
// (MULTU) operands, using a start/busy/done handshake.
//
// The multiplier works on operand magnitudes and applies the sign once, in
// the final cycle. It retires one multiplier bit per CALC cycle.
//
// Optional feature: define MUL_EARLY_TERM_EN to enable early termination.
// CALC then exits as soon as the remaining multiplier bits are all zero, and
// FIN realigns the partial product. Results are identical to the fixed-latency
// build. When the macro is undefined, CALC always runs WIDTH cycles.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   start      request a multiply (sampled only while busy = 0)
//   is_signed  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a, b       multiplicand / multiplier (sampled with start)
//   busy       high while an operation is in flight
//   done       one-cycle pulse when z holds a new result
//   z          2*WIDTH-bit product, held until the next done

module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);

  localparam int CW = $clog2(WIDTH + 1);

  // state | meaning
  // IDLE  | waiting for start; busy = 0
  // CALC  | one shift-add iteration per cycle
  // FIN   | apply sign, write z, pulse done
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // p holds {accumulator[W:0], multiplier[W-1:0]}. The extra accumulator bit
  // absorbs the carry of the add before the shift.
  logic [2*WIDTH:0]   p;
  logic [2*WIDTH:0]   p_step;
  logic [WIDTH:0]     acc_sum;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic               neg;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_dec;
  logic [2*WIDTH-1:0] prod;
  logic               load;
  logic               step;
  logic               finish;
  logic               calc_last;

  // The magnitude of the most negative value is 2^(W-1). This still fits in
  // W unsigned bits, so a plain negation is exact.
  assign a_abs = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs = (is_signed && b[WIDTH-1]) ? -b : b;

  assign acc_sum = p[2*WIDTH:WIDTH] + {1'b0, (p[0] ? mag_a : {WIDTH{1'b0}})};
  assign p_step  = {1'b0, acc_sum, p[WIDTH-1:1]};
  assign cnt_dec = cnt - CW'(1);

`ifdef MUL_EARLY_TERM_EN
  // After k iterations, the low cnt_dec bits of p_step are the multiplier
  // bits that have not been consumed yet. If they are all zero, the remaining
  // iterations would only shift.
  logic [WIDTH-1:0] rem_mask;
  logic             rem_zero;

  always_comb begin
    rem_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rem_mask[i] = (CW'(i) < cnt_dec);
    end
  end

  assign rem_zero  = ((p_step[WIDTH-1:0] & rem_mask) == '0);
  assign calc_last = (cnt_dec == '0) || rem_zero;

  // cnt holds the number of skipped iterations. Each skipped iteration would
  // have shifted p right by one bit. The top bit of p is always 0 after a CALC
  // step, so dropping it before the shift loses nothing.
  assign prod = p[2*WIDTH-1:0] >> cnt;
`else
  assign calc_last = (cnt_dec == '0);
  assign prod      = p[2*WIDTH-1:0];
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: if (calc_last) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy   = (state != IDLE);
    load   = (state == IDLE) && start;
    step   = (state == CALC);
    finish = (state == FIN);
  end

  // Datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p     <= '0;
      mag_a <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      z     <= '0;
      done  <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        p     <= {{(WIDTH+1){1'b0}}, b_abs};
        mag_a <= a_abs;
        neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        cnt   <= CW'(WIDTH);
      end else if (step) begin
        p   <= p_step;
        cnt <= cnt_dec;
      end
      if (finish) begin
        z <= neg ? -prod : prod;
      end
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
module tb_mul_iter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] z;

  mul_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .z         (z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] z;
    int             acc;
    bit             bzero;
    string          name;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   n_done = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done with z=%h, expected no done", z);
      end else begin
        exp_t e;
        int   lat;
        e   = sb.pop_front();
        lat = cyc - e.acc;
        check({e.name, "_z"}, z, e.z);
        check({e.name, "_busy_in_done"}, 64'(busy), 64'd0);
`ifdef MUL_EARLY_TERM_EN
        if (e.bzero) check({e.name, "_latency"}, 64'(lat), 64'd2);
        else         check({e.name, "_latency_bound"}, 64'(lat <= W + 1), 64'd1);
`else
        check({e.name, "_latency"}, 64'(lat), 64'(W + 1));
`endif
      end
    end
  end

  // Call at a negedge where busy = 0; returns one negedge after acceptance.
  task automatic issue(input string nm, input bit s, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [2*W-1:0] ez);
    exp_t e;
    start     = 1'b1;
    is_signed = s;
    a         = av;
    b         = bv;
    e.z       = ez;
    e.acc     = cyc + 1;
    e.bzero   = (bv == '0);
    e.name    = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_after_accept"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string nm, input int max_cyc);
    int k = 0;
    while (done !== 1'b1 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic run(input string nm, input bit s, input logic [W-1:0] av,
                     input logic [W-1:0] bv, input logic [2*W-1:0] ez);
    issue(nm, s, av, bv, ez);
    wait_done(nm, W + 8);
    @(negedge clk);
  endtask

  initial begin
    int done_before;
    reset     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_z", z, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run("s_3x5",        1'b1, 32'd3,          32'd5,          64'h0000_0000_0000_000F);
    run("s_m1x1",       1'b1, 32'hFFFF_FFFF,  32'd1,          64'hFFFF_FFFF_FFFF_FFFF);
    run("s_min_sq",     1'b1, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);
    run("u_max_sq",     1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001);
    run("s_m7xm6",      1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFA,  64'h0000_0000_0000_002A);
    run("s_min_x1",     1'b1, 32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000);
    run("u_max_x3",     1'b0, 32'hFFFF_FFFF,  32'd3,          64'h0000_0002_FFFF_FFFD);
    run("u_b0",         1'b0, 32'h0000_1234,  32'd0,          64'h0);
    run("s_m1x3",       1'b1, 32'hFFFF_FFFF,  32'd3,          64'hFFFF_FFFF_FFFF_FFFD);

    // A start while busy must be ignored; a start in the done cycle is accepted.
    issue("hs_7x6", 1'b0, 32'd7, 32'd6, 64'd42);
    repeat (8) @(negedge clk);
    start = 1'b1;
    a     = 32'd2;
    b     = 32'd2;
    @(negedge clk);
    start = 1'b0;
    check("hs_busy_hold", 64'(busy), 64'd1);
    wait_done("hs_7x6", W + 8);
    issue("hs_b2b_2x2", 1'b0, 32'd2, 32'd2, 64'd4);
    wait_done("hs_b2b_2x2", W + 8);
    @(negedge clk);

    // Reset in the middle of an operation
    issue("rst_9x9", 1'b0, 32'd9, 32'd9, 64'd81);
    repeat (13) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_z", z, 64'd0);
    sb.delete();
    done_before = n_done;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_done", 64'(n_done), 64'(done_before));

    run("post_rst_u_3x5", 1'b0, 32'd3, 32'd5, 64'd15);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
